// File: rtl/dpctrl_pkg.sv
// Shared definitions for the datapath controller: opcodes, condition codes,
// FSM state encoding, the decoded strobe bundle and the branch-condition helper.
package dpctrl_pkg;

    // Major opcodes, instr[15:11]
    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LLI = 5'b00001;
    localparam logic [4:0] OP_LHI = 5'b00010;
    localparam logic [4:0] OP_LDR = 5'b00011;
    localparam logic [4:0] OP_STR = 5'b00101;
    localparam logic [4:0] OP_JMP = 5'b10000;
    localparam logic [4:0] OP_BCC = 5'b11000;
    localparam logic [4:0] OP_OUT = 5'b11100;
    localparam logic [4:0] OP_HLT = 5'b11111;

    // ALU sub-function, instr[1:0]
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_ADC = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SBB = 2'b11;

    // Branch condition codes, instr[10:8]
    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_NE = 3'b001;
    localparam logic [2:0] CC_CS = 3'b010;
    localparam logic [2:0] CC_CC = 3'b011;
    localparam logic [2:0] CC_MI = 3'b100;
    localparam logic [2:0] CC_PL = 3'b101;
    localparam logic [2:0] CC_VS = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } state_e;

    typedef struct packed {
        logic RF_write_en;
        logic data_write_en;
        logic Src_ALU_B;
        logic Src_Read_B;
        logic ADC;
        logic SUB;
        logic SBB;
        logic JMP;
        logic BRANCH;
        logic flag_label_PC;
        logic flag_Rm_PC;
        logic flag_Rd_PC;
        logic flag_mem_RF;
        logic flag_ALU_RF;
        logic flag_Rm_RF;
        logic flag_PC_RF;
        logic LHI;
        logic LLI;
        logic flag_OutR;
    } strobe_t;

    // nzcv is {N,Z,C,V}
    function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cc)
            CC_EQ:   cond_met = z;
            CC_NE:   cond_met = ~z;
            CC_CS:   cond_met = c;
            CC_CC:   cond_met = ~c;
            CC_MI:   cond_met = n;
            CC_PL:   cond_met = ~n;
            CC_VS:   cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dpctrl_decode.sv
// Combinational opcode decode: instruction -> datapath strobe bundle.
// Everything is forced to zero unless en is high, so no strobe leaks outside RUN.
module dpctrl_decode
    import dpctrl_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic [DW-1:0] instr,
    input  logic          en,
    input  logic [3:0]    flags,
    output strobe_t       strobes,
    output logic          is_alu,
    output logic          is_hlt
);

    logic [4:0] op;
    logic [2:0] cc;
    logic       unused_instr;

    assign op           = instr[DW-1 -: 5];
    assign cc           = instr[DW-6 -: 3];
    assign unused_instr = ^instr[DW-9:2];

    // Decode the opcode into strobes; illegal opcodes fall through as a NOP
    always_comb begin
        strobes = '0;
        is_alu  = 1'b0;
        is_hlt  = 1'b0;
        if (en) begin
            case (op)
                OP_ALU: begin
                    is_alu              = 1'b1;
                    strobes.flag_ALU_RF = 1'b1;
                    strobes.RF_write_en = 1'b1;
                    case (instr[1:0])
                        ALU_ADC: strobes.ADC = 1'b1;
                        ALU_SUB: strobes.SUB = 1'b1;
                        ALU_SBB: strobes.SBB = 1'b1;
                        default: ;
                    endcase
                end
                OP_LLI: begin
                    strobes.LLI         = 1'b1;
                    strobes.RF_write_en = 1'b1;
                end
                OP_LHI: begin
                    strobes.LHI         = 1'b1;
                    strobes.Src_Read_B  = 1'b1;
                    strobes.RF_write_en = 1'b1;
                end
                OP_LDR: begin
                    strobes.Src_ALU_B   = 1'b1;
                    strobes.flag_mem_RF = 1'b1;
                    strobes.RF_write_en = 1'b1;
                end
                OP_STR: begin
                    strobes.Src_ALU_B     = 1'b1;
                    strobes.Src_Read_B    = 1'b1;
                    strobes.data_write_en = 1'b1;
                end
                OP_JMP: begin
                    strobes.JMP           = 1'b1;
                    strobes.flag_label_PC = 1'b1;
                end
                OP_BCC: begin
                    strobes.flag_label_PC = 1'b1;
                    strobes.BRANCH        = cond_met(cc, flags);
                end
                OP_OUT:  strobes.flag_OutR = 1'b1;
                OP_HLT:  is_hlt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Datapath sequencing controller: mode FSM (IDLE -> CLEAR -> RUN -> HALT),
// NZCV flag register and instruction decode for Datapath_Module.
// Optional feature: define DPCTRL_INSTR_CNT_EN to add the instr_cnt output.
module datapath_controller
    import dpctrl_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          load_req,
    input  logic [DW-1:0] instr,
    input  logic          Pre_N,
    input  logic          Pre_Z,
    input  logic          Pre_C,
    input  logic          Pre_V,
    output logic          test_normal,
    output logic          dp_clr,
    output logic          flag_HLT,
    output logic          RF_write_en,
    output logic          data_write_en,
    output logic          Src_ALU_B,
    output logic          Src_Read_B,
    output logic          ADC,
    output logic          SUB,
    output logic          SBB,
    output logic          JMP,
    output logic          BRANCH,
    output logic          flag_label_PC,
    output logic          flag_Rm_PC,
    output logic          flag_Rd_PC,
    output logic          flag_mem_RF,
    output logic          flag_ALU_RF,
    output logic          flag_Rm_RF,
    output logic          flag_PC_RF,
    output logic          LHI,
    output logic          LLI,
    output logic          flag_OutR,
    output logic [3:0]    flags,
    output logic [1:0]    state
`ifdef DPCTRL_INSTR_CNT_EN
    ,
    output logic [15:0]   instr_cnt
`endif
);

    localparam int unsigned CntW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CntW-1:0] ClrLast = CntW'(CLR_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]      flags_q, flags_d;

    strobe_t strobes;
    logic    is_alu;
    logic    is_hlt;

    dpctrl_decode #(
        .DW (DW)
    ) u_decode (
        .instr   (instr),
        .en      (state_q == StRun),
        .flags   (flags_q),
        .strobes (strobes),
        .is_alu  (is_alu),
        .is_hlt  (is_hlt)
    );

    // Next-state, clear-counter and flag update; load_req outranks start and HLT
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        flags_d   = flags_q;
        if (is_alu) begin
            flags_d = {Pre_N, Pre_Z, Pre_C, Pre_V};
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    flags_d   = '0;
                end
            end
            StClear: begin
                if (load_req) begin
                    state_d = StIdle;
                end else if (clr_cnt_q == ClrLast) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (load_req) begin
                    state_d = StIdle;
                end else if (is_hlt) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (load_req) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    flags_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, clear counter and flag registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            flags_q   <= flags_d;
        end
    end

`ifdef DPCTRL_INSTR_CNT_EN
    logic [15:0] instr_cnt_q, instr_cnt_d;

    // Count every RUN cycle (HLT included); wraps naturally at 16 bits
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if (state_q == StClear) begin
            instr_cnt_d = '0;
        end else if (state_q == StRun) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
        end
    end

    // Instruction counter register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            instr_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
`endif

    // Mode outputs follow the registered state, so clr forces them immediately
    always_comb begin
        test_normal = (state_q == StIdle);
        dp_clr      = (state_q == StClear);
        flag_HLT    = (state_q == StRun);
        flags       = flags_q;
        state       = state_q;
    end

    assign RF_write_en   = strobes.RF_write_en;
    assign data_write_en = strobes.data_write_en;
    assign Src_ALU_B     = strobes.Src_ALU_B;
    assign Src_Read_B    = strobes.Src_Read_B;
    assign ADC           = strobes.ADC;
    assign SUB           = strobes.SUB;
    assign SBB           = strobes.SBB;
    assign JMP           = strobes.JMP;
    assign BRANCH        = strobes.BRANCH;
    assign flag_label_PC = strobes.flag_label_PC;
    assign flag_Rm_PC    = strobes.flag_Rm_PC;
    assign flag_Rd_PC    = strobes.flag_Rd_PC;
    assign flag_mem_RF   = strobes.flag_mem_RF;
    assign flag_ALU_RF   = strobes.flag_ALU_RF;
    assign flag_Rm_RF    = strobes.flag_Rm_RF;
    assign flag_PC_RF    = strobes.flag_PC_RF;
    assign LHI           = strobes.LHI;
    assign LLI           = strobes.LLI;
    assign flag_OutR     = strobes.flag_OutR;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed self-checking bench for datapath_controller.
module tb_datapath_controller;

    logic        clk;
    logic        clr;
    logic        start;
    logic        load_req;
    logic [15:0] instr;
    logic        Pre_N, Pre_Z, Pre_C, Pre_V;
    logic        test_normal, dp_clr, flag_HLT;
    logic        RF_write_en, data_write_en, Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP, BRANCH;
    logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_mem_RF, flag_ALU_RF, flag_Rm_RF;
    logic        flag_PC_RF, LHI, LLI, flag_OutR;
    logic [3:0]  flags;
    logic [1:0]  state;
`ifdef DPCTRL_INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe bit masks, MSB first in the order of the vector below
    localparam logic [18:0] M_RFW  = 19'h1 << 18;
    localparam logic [18:0] M_DWE  = 19'h1 << 17;
    localparam logic [18:0] M_SALU = 19'h1 << 16;
    localparam logic [18:0] M_SRB  = 19'h1 << 15;
    localparam logic [18:0] M_ADC  = 19'h1 << 14;
    localparam logic [18:0] M_SUB  = 19'h1 << 13;
    localparam logic [18:0] M_SBB  = 19'h1 << 12;
    localparam logic [18:0] M_JMP  = 19'h1 << 11;
    localparam logic [18:0] M_BR   = 19'h1 << 10;
    localparam logic [18:0] M_LPC  = 19'h1 << 9;
    localparam logic [18:0] M_MRF  = 19'h1 << 6;
    localparam logic [18:0] M_ARF  = 19'h1 << 5;
    localparam logic [18:0] M_LHI  = 19'h1 << 2;
    localparam logic [18:0] M_LLI  = 19'h1 << 1;
    localparam logic [18:0] M_OUT  = 19'h1 << 0;

    logic [18:0] strobes;
    assign strobes = {RF_write_en, data_write_en, Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP,
                      BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_mem_RF, flag_ALU_RF,
                      flag_Rm_RF, flag_PC_RF, LHI, LLI, flag_OutR};

    datapath_controller #(
        .DW         (16),
        .CLR_CYCLES (2)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .start         (start),
        .load_req      (load_req),
        .instr         (instr),
        .Pre_N         (Pre_N),
        .Pre_Z         (Pre_Z),
        .Pre_C         (Pre_C),
        .Pre_V         (Pre_V),
        .test_normal   (test_normal),
        .dp_clr        (dp_clr),
        .flag_HLT      (flag_HLT),
        .RF_write_en   (RF_write_en),
        .data_write_en (data_write_en),
        .Src_ALU_B     (Src_ALU_B),
        .Src_Read_B    (Src_Read_B),
        .ADC           (ADC),
        .SUB           (SUB),
        .SBB           (SBB),
        .JMP           (JMP),
        .BRANCH        (BRANCH),
        .flag_label_PC (flag_label_PC),
        .flag_Rm_PC    (flag_Rm_PC),
        .flag_Rd_PC    (flag_Rd_PC),
        .flag_mem_RF   (flag_mem_RF),
        .flag_ALU_RF   (flag_ALU_RF),
        .flag_Rm_RF    (flag_Rm_RF),
        .flag_PC_RF    (flag_PC_RF),
        .LHI           (LHI),
        .LLI           (LLI),
        .flag_OutR     (flag_OutR),
        .flags         (flags),
        .state         (state)
`ifdef DPCTRL_INSTR_CNT_EN
        ,
        .instr_cnt     (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and check the combinational strobes
    task automatic apply(input string tag, input logic [15:0] i, input logic [18:0] exp);
        instr = i;
        #1;
        check(tag, {13'd0, strobes}, {13'd0, exp});
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        load_req = 1'b0;
        instr    = 16'h0000;
        {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'b0000;
        #2;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_test_normal", {31'd0, test_normal}, 32'd1);
        check("rst_dp_clr", {31'd0, dp_clr}, 32'd0);
        check("rst_flag_hlt", {31'd0, flag_HLT}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_strobes", {13'd0, strobes}, 32'd0);
        cyc();
        cyc();
        clr = 1'b0;

        // Start: two CLEAR cycles, then RUN
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        check("clear1_state", {30'd0, state}, 32'd1);
        check("clear1_dp_clr", {31'd0, dp_clr}, 32'd1);
        check("clear1_test_normal", {31'd0, test_normal}, 32'd0);
        cyc();
        check("clear2_dp_clr", {31'd0, dp_clr}, 32'd1);
        cyc();
        check("run_state", {30'd0, state}, 32'd2);
        check("run_dp_clr", {31'd0, dp_clr}, 32'd0);
        check("run_flag_hlt", {31'd0, flag_HLT}, 32'd1);

        // Decode of each opcode class
        apply("ldr", 16'b00011_001_000_00000, M_SALU | M_MRF | M_RFW);
        cyc();
        Pre_Z = 1'b1;
        apply("add", 16'h0000, M_RFW | M_ARF);
        check("flags_before_edge", {28'd0, flags}, 32'd0);
        cyc();
        Pre_Z = 1'b0;
        check("flags_after_add", {28'd0, flags}, 32'h4);
        apply("beq_taken", 16'hC000, M_LPC | M_BR);
        cyc();
        apply("adc", 16'h0001, M_RFW | M_ARF | M_ADC);
        cyc();
        check("flags_after_adc", {28'd0, flags}, 32'h0);
        apply("beq_not_taken", 16'hC000, M_LPC);
        apply("bne_taken", 16'hC100, M_LPC | M_BR);
        cyc();
        {Pre_N, Pre_V} = 2'b11;
        apply("sub", 16'h0002, M_RFW | M_ARF | M_SUB);
        cyc();
        {Pre_N, Pre_V} = 2'b00;
        check("flags_after_sub", {28'd0, flags}, 32'h9);
        apply("bmi_taken", 16'hC400, M_LPC | M_BR);
        apply("bvs_taken", 16'hC600, M_LPC | M_BR);
        apply("bcs_not_taken", 16'hC200, M_LPC);
        apply("bal_taken", 16'hC700, M_LPC | M_BR);
        apply("sbb", 16'h0003, M_RFW | M_ARF | M_SBB);
        apply("str", 16'h2800, M_SALU | M_SRB | M_DWE);
        apply("jmp", 16'h8000, M_JMP | M_LPC);
        apply("lhi", 16'h1000, M_LHI | M_SRB | M_RFW);
        apply("lli", 16'h0800, M_LLI | M_RFW);
        apply("out", 16'hE000, M_OUT);
        apply("illegal", 16'h2000, 19'd0);
        check("illegal_pc_adv", {31'd0, flag_HLT}, 32'd1);
        cyc();
        check("flags_held", {28'd0, flags}, 32'h9);

        // HLT: no strobes, then HALT
        apply("hlt", 16'hF800, 19'd0);
        cyc();
        check("halt_state", {30'd0, state}, 32'd3);
        check("halt_flag_hlt", {31'd0, flag_HLT}, 32'd0);
        apply("halt_gated", 16'h2800, 19'd0);

        // HALT: load_req beats start
        start    = 1'b1;
        load_req = 1'b1;
        cyc();
        start    = 1'b0;
        load_req = 1'b0;
        check("halt_loadreq_wins", {30'd0, state}, 32'd0);

        // IDLE: load_req ignored, start wins; flags cleared on CLEAR entry
        start    = 1'b1;
        load_req = 1'b1;
        cyc();
        start    = 1'b0;
        load_req = 1'b0;
        check("idle_start_state", {30'd0, state}, 32'd1);
        check("clear_flags_zero", {28'd0, flags}, 32'd0);
        cyc();
        cyc();
        check("run2_state", {30'd0, state}, 32'd2);

`ifdef DPCTRL_INSTR_CNT_EN
        instr = 16'h2000;
        check("cnt_start", {16'd0, instr_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) cyc();
        check("cnt_five", {16'd0, instr_cnt}, 32'd5);
`endif

        // load_req in RUN with STR present
        load_req = 1'b1;
        apply("str_before_load", 16'h2800, M_SALU | M_SRB | M_DWE);
        cyc();
        load_req = 1'b0;
        #1;
        check("load_state", {30'd0, state}, 32'd0);
        check("load_test_normal", {31'd0, test_normal}, 32'd1);
        check("load_dwe", {31'd0, data_write_en}, 32'd0);

        // Back to RUN, then async clr in the middle of an ALU op
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        check("run3_state", {30'd0, state}, 32'd2);
        {Pre_Z, Pre_C} = 2'b11;
        apply("alu_before_clr", 16'h0000, M_RFW | M_ARF);
        cyc();
        check("flags_before_clr", {28'd0, flags}, 32'h6);
        clr = 1'b1;
        #1;
        check("clr_flags", {28'd0, flags}, 32'd0);
        check("clr_rfw", {31'd0, RF_write_en}, 32'd0);
        check("clr_state", {30'd0, state}, 32'd0);
        check("clr_test_normal", {31'd0, test_normal}, 32'd1);
        cyc();
        clr = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
